// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit (mult_div_unit).
// Holds the default operand width, the MDU_OP encodings, the FSM state type
// and the divide-by-zero quotient constant.
package mdu_pkg;

    // Default operand width; HI and LO are each this wide.
    localparam int XLEN_DEFAULT = 32;

    // MDU_OP encodings (3'b11x are no-ops).
    localparam logic [2:0] MDU_OP_MULT  = 3'b000;
    localparam logic [2:0] MDU_OP_MULTU = 3'b001;
    localparam logic [2:0] MDU_OP_DIV   = 3'b010;
    localparam logic [2:0] MDU_OP_DIVU  = 3'b011;
    localparam logic [2:0] MDU_OP_MTHI  = 3'b100;
    localparam logic [2:0] MDU_OP_MTLO  = 3'b101;

    // Quotient returned for any divide by zero. Kept 64 bits wide so it can
    // be sliced for any XLEN up to 64.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIX,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/mdu_divider.sv
// Restoring-divide step datapath for mult_div_unit: holds the divisor, the
// partial remainder and the quotient shift register. The quotient register
// starts out holding the dividend; each step shifts one dividend bit into the
// remainder and one quotient bit in from the right.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem,
    output logic [XLEN-1:0] quo
);

    logic [XLEN-1:0] divisor_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Trial subtraction of the divisor from the shifted partial remainder.
    // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, divisor_q};
    end

    // Load operands, then restore or keep the trial difference one bit per step.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
        end else if (load) begin
            divisor_q <= divisor;
            rem_q     <= '0;
            quo_q     <= dividend;
        end else if (step) begin
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= shifted[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    assign rem = rem_q;
    assign quo = quo_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU use radix-2 shift-add, DIV/DIVU use restoring division
// (mdu_divider); both take XLEN iterations on magnitudes, and signs are
// applied in FIX. MTHI/MTLO write HI/LO directly when the unit is not busy.
// Optional feature macro: MDU_DIV0_FLAG_EN adds the DIV_BY_ZERO output.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            MDU_START,
    input  logic [2:0]      MDU_OP,
    input  logic [XLEN-1:0] MDU_IN_1,
    input  logic [XLEN-1:0] MDU_IN_2,
    output logic            MDU_BUSY,
    output logic            MDU_DONE,
    output logic [XLEN-1:0] HI_OUT,
    output logic [XLEN-1:0] LO_OUT
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic            DIV_BY_ZERO
`endif
);

    localparam int CNT_W = $clog2(XLEN);

    mdu_state_t      state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_raw;
    logic [XLEN-1:0] b_raw;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] p_hi;
    logic [XLEN-1:0] p_lo;
    logic [CNT_W-1:0] cnt;
    logic            prod_neg;
    logic            rem_neg;
    logic            div_zero;
    logic            busy_q;
    logic            done_q;
    logic            div0_flag;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    logic            is_signed;
    logic            is_div;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] div_quo;
    logic            div_load;
    logic            div_step;

    // Decode the latched op and form operand magnitudes and the signed product.
    always_comb begin
        is_signed = ~op_q[0];
        is_div    = op_q[1];
        a_abs     = (is_signed && a_raw[XLEN-1]) ? -a_raw : a_raw;
        b_abs     = (is_signed && b_raw[XLEN-1]) ? -b_raw : b_raw;
        mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
        prod_fix  = prod_neg ? -{p_hi, p_lo} : {p_hi, p_lo};
        div_load  = (state == LOAD) && is_div;
        div_step  = (state == ITER) && is_div;
    end

    mdu_divider #(.XLEN(XLEN)) u_divider (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (div_load),
        .step     (div_step),
        .dividend (a_abs),
        .divisor  (b_abs),
        .rem      (div_rem),
        .quo      (div_quo)
    );

    // Control FSM, multiplier shift-add and HI/LO writeback.
    // NOTE: datapath registers are reset too, so an aborted op leaves no stale partial results.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            op_q      <= '0;
            a_raw     <= '0;
            b_raw     <= '0;
            mcand     <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            cnt       <= '0;
            prod_neg  <= 1'b0;
            rem_neg   <= 1'b0;
            div_zero  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            div0_flag <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (MDU_START) begin
                        case (MDU_OP)
                            MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
                                op_q      <= MDU_OP;
                                a_raw     <= MDU_IN_1;
                                b_raw     <= MDU_IN_2;
                                busy_q    <= 1'b1;
                                div0_flag <= 1'b0;
                                state     <= LOAD;
                            end
                            MDU_OP_MTHI: hi_q <= MDU_IN_1;
                            MDU_OP_MTLO: lo_q <= MDU_IN_1;
                            default: ;
                        endcase
                    end
                end
                LOAD: begin
                    mcand    <= a_abs;
                    p_hi     <= '0;
                    p_lo     <= b_abs;
                    cnt      <= '0;
                    prod_neg <= is_signed && (a_raw[XLEN-1] ^ b_raw[XLEN-1]);
                    rem_neg  <= is_signed && a_raw[XLEN-1];
                    div_zero <= (b_raw == '0);
                    state    <= ITER;
                end
                ITER: begin
                    if (!is_div) begin
                        p_hi <= mul_sum[XLEN:1];
                        p_lo <= {mul_sum[0], p_lo[XLEN-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        hi_q <= prod_fix[2*XLEN-1:XLEN];
                        lo_q <= prod_fix[XLEN-1:0];
                    end else if (div_zero) begin
                        hi_q      <= a_raw;
                        lo_q      <= DIV0_QUOTIENT[XLEN-1:0];
                        div0_flag <= 1'b1;
                    end else begin
                        // Quotient sign is the XOR of operand signs, as for the product.
                        hi_q <= rem_neg  ? -div_rem : div_rem;
                        lo_q <= prod_neg ? -div_quo : div_quo;
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign MDU_BUSY = busy_q;
    assign MDU_DONE = done_q;
    assign HI_OUT   = hi_q;
    assign LO_OUT   = lo_q;

`ifdef MDU_DIV0_FLAG_EN
    assign DIV_BY_ZERO = div0_flag;
`else
    // Flag register only observable when the feature is built in.
    logic unused_div0;
    assign unused_div0 = div0_flag;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (default XLEN = 32).
// Checks DIV_BY_ZERO as well when built with MDU_DIV0_FLAG_EN.
module tb_mult_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] in_1;
    logic [31:0] in_2;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_DIV0_FLAG_EN
    logic        div0;
`endif

    int checks = 0;
    int errors = 0;

    mult_div_unit dut (
        .CLK       (clk),
        .RESET     (rst_n),
        .MDU_START (start),
        .MDU_OP    (mdu_op),
        .MDU_IN_1  (in_1),
        .MDU_IN_2  (in_2),
        .MDU_BUSY  (busy),
        .MDU_DONE  (done),
        .HI_OUT    (hi),
        .LO_OUT    (lo)
`ifdef MDU_DIV0_FLAG_EN
        ,
        .DIV_BY_ZERO (div0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one arithmetic op and wait for DONE; optionally inject a second
    // START (hz_op/hz_a) hz_cyc cycles after acceptance. Returns at #1 after
    // the edge that raised DONE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hz_cyc,
                          input logic [2:0] hz_op, input logic [31:0] hz_a);
        int n;
        @(negedge clk);
        start = 1'b1; mdu_op = op; in_1 = a; in_2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check({tag, "_busy_rise"}, busy, 1);
        while (!done && n < 100) begin
            if (n == hz_cyc) begin
                start = 1'b1; mdu_op = hz_op; in_1 = hz_a; in_2 = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_latency"}, n, 35);
        check({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0; start = 1'b0; mdu_op = 3'b110; in_1 = '0; in_2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clk); rst_n = 1'b1;

        run_op("mult", 3'b000, 32'd7, 32'hFFFF_FFFD, 0, 3'b110, 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        // Issued on the DONE cycle of the previous op: back-to-back acceptance.
        run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'b110, 0);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2, 0, 3'b110, 0);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);

        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'b110, 0);
        check("div_ovf_hi", hi, 32'h0);
        check("div_ovf_lo", lo, 32'h8000_0000);

        run_op("div_negdiv", 3'b010, 32'd7, 32'hFFFF_FFFE, 0, 3'b110, 0);
        check("div_negdiv_hi", hi, 32'd1);
        check("div_negdiv_lo", lo, 32'hFFFF_FFFD);

        run_op("divu0", 3'b011, 32'd100, 32'd0, 0, 3'b110, 0);
        check("divu0_hi", hi, 32'h64);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
`ifdef MDU_DIV0_FLAG_EN
        check("divu0_flag", div0, 1);
`endif

        run_op("divu", 3'b011, 32'd9, 32'd3, 0, 3'b110, 0);
        check("divu_hi", hi, 32'd0);
        check("divu_lo", lo, 32'd3);
`ifdef MDU_DIV0_FLAG_EN
        check("divu_flag_clr", div0, 0);
`endif

        run_op("div0s", 3'b010, 32'hFFFF_FFFB, 32'd0, 0, 3'b110, 0);
        check("div0s_hi", hi, 32'hFFFF_FFFB);
        check("div0s_lo", lo, 32'hFFFF_FFFF);

        run_op("hz_mthi", 3'b000, 32'd7, 32'hFFFF_FFFD, 5, 3'b100, 32'h1234);
        check("hz_mthi_hi", hi, 32'hFFFF_FFFF);
        check("hz_mthi_lo", lo, 32'hFFFF_FFEB);

        run_op("hz_divu", 3'b001, 32'd6, 32'd5, 5, 3'b011, 32'd50);
        check("hz_divu_hi", hi, 32'd0);
        check("hz_divu_lo", lo, 32'd30);

        // MTLO from IDLE.
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; mdu_op = 3'b101; in_1 = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        start = 1'b0;
        check("mtlo_lo", lo, 32'hA5A5_A5A5);
        check("mtlo_hi", hi, 32'd0);
        check("mtlo_busy", busy, 0);
        @(posedge clk); #1;
        check("mtlo_nodone", done, 0);

        // No-op code leaves everything unchanged.
        @(negedge clk);
        start = 1'b1; mdu_op = 3'b110; in_1 = 32'h5555_5555;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("nop_lo", lo, 32'hA5A5_A5A5);
        check("nop_busy", busy, 0);

        // Reset mid-MULT aborts the op.
        @(negedge clk);
        start = 1'b1; mdu_op = 3'b000; in_1 = 32'd7; in_2 = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        @(negedge clk); rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("abort_nodone", done_seen, 0);
        check("abort_lo_hold", lo, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
